// File: rtl/console_writer.sv
// Character console writer: turns a character stream into video-memory writes with cursor
// tracking and CR/LF/BS handling. Define CONSOLE_WRITER_SCROLL_EN to enable scroll-and-clear.
module console_writer #(
  parameter int unsigned COLS = 100,
  parameter int unsigned ROWS = 30
) (
  input  logic       clk,
  input  logic       reset_low,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_char,
  output logic       vram_write_valid,
  input  logic       vram_write_ready,
  output logic [4:0] vram_write_row,
  output logic [6:0] vram_write_col,
  output logic [7:0] vram_write_char,
  output logic [4:0] top_row
);

  localparam logic [4:0] RowMax = 5'(ROWS - 1);
  localparam logic [6:0] ColMax = 7'(COLS - 1);

  typedef enum logic [1:0] {StIdle, StWrite, StClear} state_e;

  state_e     state_q;
  logic [4:0] row_q;
  logic [6:0] col_q;
  logic [4:0] top_q;
  logic       ready_q;
  logic       valid_q;
  logic [4:0] wr_row_q;
  logic [6:0] wr_col_q;
  logic [7:0] wr_char_q;

  logic [4:0] row_inc;
  logic [4:0] top_inc;
  logic       scroll_hit;

  always_comb begin
    row_inc = (row_q == RowMax) ? 5'd0 : row_q + 5'd1;
    top_inc = (top_q == RowMax) ? 5'd0 : top_q + 5'd1;
`ifdef CONSOLE_WRITER_SCROLL_EN
    scroll_hit = (row_inc == top_q);
`else
    scroll_hit = 1'b0;
`endif
  end

  always_ff @(posedge clk or negedge reset_low) begin
    if (!reset_low) begin
      state_q   <= StIdle;
      row_q     <= 5'd0;
      col_q     <= 7'd0;
      top_q     <= 5'd0;
      ready_q   <= 1'b0;
      valid_q   <= 1'b0;
      wr_row_q  <= 5'd0;
      wr_col_q  <= 7'd0;
      wr_char_q <= 8'd0;
    end else begin
      unique case (state_q)
        StIdle: begin
          ready_q <= 1'b1;
          if (in_valid && ready_q) begin
            case (in_char)
              8'h0D: col_q <= 7'd0;
              8'h08: if (col_q != 7'd0) col_q <= col_q - 7'd1;
              8'h0A: begin
                row_q <= row_inc;
                if (scroll_hit) begin
                  top_q     <= top_inc;
                  state_q   <= StClear;
                  ready_q   <= 1'b0;
                  valid_q   <= 1'b1;
                  wr_row_q  <= row_inc;
                  wr_col_q  <= 7'd0;
                  wr_char_q <= 8'h20;
                end
              end
              default: begin
                state_q   <= StWrite;
                ready_q   <= 1'b0;
                valid_q   <= 1'b1;
                wr_row_q  <= row_q;
                wr_col_q  <= col_q;
                wr_char_q <= in_char;
              end
            endcase
          end
        end
        StWrite: begin
          if (vram_write_ready) begin
            if (col_q != ColMax) begin
              col_q   <= col_q + 7'd1;
              state_q <= StIdle;
              ready_q <= 1'b1;
              valid_q <= 1'b0;
            end else begin
              col_q <= 7'd0;
              row_q <= row_inc;
              if (scroll_hit) begin
                top_q     <= top_inc;
                state_q   <= StClear;
                wr_row_q  <= row_inc;
                wr_col_q  <= 7'd0;
                wr_char_q <= 8'h20;
              end else begin
                state_q <= StIdle;
                ready_q <= 1'b1;
                valid_q <= 1'b0;
              end
            end
          end
        end
        StClear: begin
          if (vram_write_ready) begin
            if (wr_col_q == ColMax) begin
              state_q <= StIdle;
              ready_q <= 1'b1;
              valid_q <= 1'b0;
            end else begin
              wr_col_q <= wr_col_q + 7'd1;
            end
          end
        end
        default: begin
          state_q <= StIdle;
          ready_q <= 1'b0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready         = ready_q;
  assign vram_write_valid = valid_q;
  assign vram_write_row   = wr_row_q;
  assign vram_write_col   = wr_col_q;
  assign vram_write_char  = wr_char_q;
  assign top_row          = top_q;

endmodule

// File: tb/tb_console_writer.sv
// Scoreboard bench for console_writer: a cursor model queues expected vram writes as
// characters are sent; a negedge monitor pops and compares each completed write.
module tb_console_writer;

  localparam int unsigned COLS = 100;
  localparam int unsigned ROWS = 30;
`ifdef CONSOLE_WRITER_SCROLL_EN
  localparam int LfWrites = 100;
  localparam int LfTop    = 1;
`else
  localparam int LfWrites = 0;
  localparam int LfTop    = 0;
`endif

  logic       clk;
  logic       reset_low;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_char;
  logic       vram_write_valid;
  logic       vram_write_ready;
  logic [4:0] vram_write_row;
  logic [6:0] vram_write_col;
  logic [7:0] vram_write_char;
  logic [4:0] top_row;

  int          total;
  int          bad;
  int          wr_cnt;
  logic [19:0] exp_q[$];
  logic [19:0] mon_e;
  int          m_row, m_col, m_top;
  bit          rand_rdy;

  console_writer #(.COLS(COLS), .ROWS(ROWS)) dut (
    .clk              (clk),
    .reset_low        (reset_low),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_char          (in_char),
    .vram_write_valid (vram_write_valid),
    .vram_write_ready (vram_write_ready),
    .vram_write_row   (vram_write_row),
    .vram_write_col   (vram_write_col),
    .vram_write_char  (vram_write_char),
    .top_row          (top_row)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (reset_low) begin
      check("rdy_valid_excl", {31'd0, in_ready & vram_write_valid}, 32'd0);
      if (vram_write_valid && vram_write_ready) begin
        wr_cnt++;
        if (exp_q.size() == 0) begin
          check("extra_write", {12'd0, vram_write_row, vram_write_col, vram_write_char},
                32'hFFFFFFFF);
        end else begin
          mon_e = exp_q.pop_front();
          check("write", {12'd0, vram_write_row, vram_write_col, vram_write_char},
                {12'd0, mon_e});
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_rdy) vram_write_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic push_exp(input int r, input int c, input logic [7:0] ch);
    exp_q.push_back({5'(r), 7'(c), ch});
  endtask

  task automatic model_newline();
    m_row = (m_row == ROWS - 1) ? 0 : m_row + 1;
`ifdef CONSOLE_WRITER_SCROLL_EN
    if (m_row == m_top) begin
      m_top = (m_top == ROWS - 1) ? 0 : m_top + 1;
      for (int c = 0; c < COLS; c++) push_exp(m_row, c, 8'h20);
    end
`endif
  endtask

  task automatic model_char(input logic [7:0] ch);
    case (ch)
      8'h0D: m_col = 0;
      8'h08: if (m_col > 0) m_col--;
      8'h0A: model_newline();
      default: begin
        push_exp(m_row, m_col, ch);
        if (m_col < COLS - 1) m_col++;
        else begin
          m_col = 0;
          model_newline();
        end
      end
    endcase
  endtask

  task automatic send_char(input logic [7:0] ch);
    int n = 0;
    while (!in_ready && n < 2000) begin
      tick();
      n++;
    end
    if (!in_ready) begin
      check("ready_timeout", {31'd0, in_ready}, 32'd1);
    end else begin
      in_valid = 1'b1;
      in_char  = ch;
      model_char(ch);
      tick();
      in_valid = 1'b0;
      in_char  = 8'($urandom);
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q.size() != 0 || !in_ready) && n < 10000) begin
      tick();
      n++;
    end
    check("drain_left", exp_q.size(), 32'd0);
    check("drain_ready", {31'd0, in_ready}, 32'd1);
    check("top_row", {27'd0, top_row}, m_top);
  endtask

  task automatic check_reset_outputs();
    check("rst_valid", {31'd0, vram_write_valid}, 32'd0);
    check("rst_row", {27'd0, vram_write_row}, 32'd0);
    check("rst_col", {25'd0, vram_write_col}, 32'd0);
    check("rst_char", {24'd0, vram_write_char}, 32'd0);
    check("rst_top", {27'd0, top_row}, 32'd0);
    check("rst_ready", {31'd0, in_ready}, 32'd0);
  endtask

  // Asserts reset off the clock edge so the asynchronous path is what gets observed.
  task automatic do_reset();
    #1;
    reset_low = 1'b0;
    #1;
    check_reset_outputs();
    exp_q.delete();
    m_row = 0;
    m_col = 0;
    m_top = 0;
    vram_write_ready = 1'b1;
    tick();
    tick();
    reset_low = 1'b1;
    check("rdy_pre_edge", {31'd0, in_ready}, 32'd0);
    tick();
    check("rdy_post_edge", {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    int base;
    int n;
    int r;
    total = 0;
    bad = 0;
    wr_cnt = 0;
    rand_rdy = 1'b0;
    reset_low = 1'b1;
    in_valid = 1'b0;
    in_char = 8'h00;
    vram_write_ready = 1'b1;
    do_reset();

    // First character lands one cycle after acceptance.
    send_char(8'h41);
    check("a_valid", {31'd0, vram_write_valid}, 32'd1);
    check("a_row", {27'd0, vram_write_row}, 32'd0);
    check("a_col", {25'd0, vram_write_col}, 32'd0);
    check("a_char", {24'd0, vram_write_char}, 32'h41);
    wait_drain();

    // Stalled write holds steady.
    vram_write_ready = 1'b0;
    send_char(8'h42);
    for (int i = 0; i < 5; i++) begin
      check("stall_valid", {31'd0, vram_write_valid}, 32'd1);
      check("stall_row", {27'd0, vram_write_row}, 32'd0);
      check("stall_col", {25'd0, vram_write_col}, 32'd1);
      check("stall_char", {24'd0, vram_write_char}, 32'h42);
      check("stall_ready", {31'd0, in_ready}, 32'd0);
      tick();
    end
    vram_write_ready = 1'b1;
    wait_drain();

    // Full row then wrap to the next row.
    send_char(8'h0D);
    for (int i = 0; i < COLS; i++) send_char(8'h30 + 8'(i % 10));
    send_char(8'h21);
    wait_drain();

    // X BS BS CR LF: exactly one write, then next char at row 2 col 0.
    send_char(8'h0D);
    base = wr_cnt;
    send_char(8'h58);
    send_char(8'h08);
    send_char(8'h08);
    send_char(8'h0D);
    send_char(8'h0A);
    wait_drain();
    check("ctl_writes", wr_cnt - base, 32'd1);
    send_char(8'h59);
    wait_drain();

    // A full lap of LFs from a fresh reset.
    do_reset();
    base = wr_cnt;
    for (int i = 0; i < ROWS; i++) send_char(8'h0A);
    wait_drain();
    check("lf_writes", wr_cnt - base, LfWrites);
    check("lf_top", {27'd0, top_row}, LfTop);
    send_char(8'h5A);
    wait_drain();

    // Random mix with random back-pressure.
    rand_rdy = 1'b1;
    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 9);
      case (r)
        0: send_char(8'h0A);
        1: send_char(8'h0D);
        2: send_char(8'h08);
        3: send_char(8'h01);
        default: send_char(8'h20 + 8'($urandom_range(0, 94)));
      endcase
    end
    wait_drain();
    rand_rdy = 1'b0;
    vram_write_ready = 1'b1;
    wait_drain();

    // Reset in the middle of an operation; nothing resumes afterwards.
`ifdef CONSOLE_WRITER_SCROLL_EN
    do_reset();
    base = wr_cnt;
    for (int i = 0; i < ROWS; i++) send_char(8'h0A);
    n = 0;
    while (wr_cnt - base < 40 && n < 1000) begin
      tick();
      n++;
    end
    check("clear_col", {25'd0, vram_write_col}, 32'd40);
    check("clear_valid", {31'd0, vram_write_valid}, 32'd1);
`else
    vram_write_ready = 1'b0;
    send_char(8'h51);
    tick();
    tick();
    check("mid_valid", {31'd0, vram_write_valid}, 32'd1);
`endif
    do_reset();
    base = wr_cnt;
    for (int i = 0; i < 20; i++) tick();
    check("no_resume", wr_cnt - base, 32'd0);
    check("post_rst_valid", {31'd0, vram_write_valid}, 32'd0);
    send_char(8'h52);
    wait_drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
